// File: rtl/pipe_pkg.sv
// Shared types and default vectors for the fetch-PC controller.
// Holds the FSM state encoding and the kind of a latched request.
package pipe_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    typedef enum logic {
        PK_REDIR = 1'b0,
        PK_TRAP  = 1'b1
    } pend_kind_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0008;

endpackage : pipe_pkg

// File: rtl/pc_reg.sv
// Fetch PC storage: WIDTH-bit register with load enable and a
// synchronous active-low reset to RST_VAL.
module pc_reg #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pc_q
);

    // NOTE: sequential state is always assigned with <= so every flop samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            pc_q <= RST_VAL;
        end else if (load_i) begin
            pc_q <= pc_d;
        end
    end

endmodule : pc_reg

// File: rtl/pipe_pc_ctrl.sv
// Fetch PC controller: sequential stepping, redirects and traps, with one
// request latched while fetch is stalled and replayed when it resumes.
module pipe_pc_ctrl
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             we,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             trap_valid,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             flush,
    output logic             misalign,
    output logic             pend
);

    localparam logic [WIDTH-1:0] STEP_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] STEP_INC  = WIDTH'(STEP);

    state_e           state_q, state_d;
    pend_kind_e       kind_q, kind_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             pmis_q, pmis_d;
    logic             flush_q, flush_d;
    logic             mis_q, mis_d;
    logic             valid_q;

    logic             pc_load;
    logic [WIDTH-1:0] pc_next;
    logic             redir_mis;

    assign redir_mis = |(redir_target & STEP_MASK);

    pc_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RESET_VEC)
    ) u_pc_reg (
        .clk    (clk),
        .clrn   (clrn),
        .load_i (pc_load),
        .pc_d   (pc_next),
        .pc_q   (pc)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        tgt_d   = tgt_q;
        pmis_d  = pmis_q;
        pc_load = 1'b0;
        pc_next = pc + STEP_INC;
        flush_d = 1'b0;
        mis_d   = 1'b0;

        if (we) begin
            pc_load = 1'b1;
            state_d = ST_RUN;
            kind_d  = PK_REDIR;
            pmis_d  = 1'b0;
            if (trap_valid) begin
                pc_next = TRAP_VEC;
                flush_d = 1'b1;
            end else if (state_q == ST_PEND) begin
                // A live redirect arriving with a pending entry is dropped.
                pc_next = (kind_q == PK_TRAP) ? TRAP_VEC : tgt_q;
                flush_d = 1'b1;
                mis_d   = pmis_q;
            end else if (redir_valid) begin
                flush_d = 1'b1;
                if (redir_mis) begin
                    pc_next = TRAP_VEC;
                    mis_d   = 1'b1;
                end else begin
                    pc_next = redir_target;
                end
            end
        end else begin
            if (trap_valid) begin
                state_d = ST_PEND;
                kind_d  = PK_TRAP;
                pmis_d  = 1'b0;
            end else if (redir_valid && !(state_q == ST_PEND && kind_q == PK_TRAP)) begin
                // Misalignment is resolved now; the pulse waits for the load.
                state_d = ST_PEND;
                kind_d  = redir_mis ? PK_TRAP : PK_REDIR;
                tgt_d   = redir_target;
                pmis_d  = redir_mis;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= ST_RUN;
            kind_q  <= PK_REDIR;
            tgt_q   <= '0;
            pmis_q  <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            tgt_q   <= tgt_d;
            pmis_q  <= pmis_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            valid_q <= 1'b1;
        end
    end

    assign pc_valid = valid_q;
    assign flush    = flush_q;
    assign misalign = mis_q;
    assign pend     = (state_q == ST_PEND);

endmodule : pipe_pc_ctrl

// File: tb/tb_pipe_pc_ctrl.sv
// Self-checking bench for pipe_pc_ctrl: a table of per-cycle vectors plus
// hand-written wrap and reset-while-pending sequences, via a scoreboard queue.
module tb_pipe_pc_ctrl;

    typedef struct {
        logic        clrn;
        logic        we;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic        pend;
        logic        valid;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic        pend;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        we;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        trap_valid;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        misalign;
    logic        pend;

    int n_checks = 0;
    int n_errors = 0;

    vec_t tbl[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_pc_ctrl dut (
        .clk          (clk),
        .clrn         (clrn),
        .we           (we),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .trap_valid   (trap_valid),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .misalign     (misalign),
        .pend         (pend)
    );

    task automatic check(input string name, input int step_no,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, step_no, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic w, input logic rv, input logic [31:0] rt,
                       input logic tv, input logic [31:0] epc, input logic ef,
                       input logic em, input logic ep, input logic ev);
        vec_t v;
        v.clrn = c; v.we = w; v.rv = rv; v.rt = rt; v.tv = tv;
        v.pc = epc; v.flush = ef; v.mis = em; v.pend = ep; v.valid = ev;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, push its expectation, compare after the edge.
    task automatic step(input vec_t v, input int step_no);
        exp_t e;
        exp_t got;
        @(negedge clk);
        clrn         = v.clrn;
        we           = v.we;
        redir_valid  = v.rv;
        redir_target = v.rt;
        trap_valid   = v.tv;
        e.pc = v.pc; e.flush = v.flush; e.mis = v.mis; e.pend = v.pend; e.valid = v.valid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("pc",       step_no, pc,                got.pc);
        check("flush",    step_no, {31'b0, flush},    {31'b0, got.flush});
        check("misalign", step_no, {31'b0, misalign}, {31'b0, got.mis});
        check("pend",     step_no, {31'b0, pend},     {31'b0, got.pend});
        check("pc_valid", step_no, {31'b0, pc_valid}, {31'b0, got.valid});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   n;

        // clrn we rv target tv | pc flush mis pend valid
        add(0, 1, 1, 32'h0000_0500, 1, 32'h0000_0000, 0, 0, 0, 0);
        add(0, 1, 0, 32'h0,         0, 32'h0000_0000, 0, 0, 0, 0);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0004, 0, 0, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0008, 0, 0, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_000C, 0, 0, 0, 1);
        add(1, 1, 1, 32'h0000_0100, 0, 32'h0000_0100, 1, 0, 0, 1);
        add(1, 1, 1, 32'h0000_0200, 0, 32'h0000_0200, 1, 0, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0204, 0, 0, 0, 1);
        add(1, 0, 0, 32'h0,         0, 32'h0000_0204, 0, 0, 0, 1);
        // stalled redirect, then trap overrides, later redirect cannot displace it
        add(1, 0, 1, 32'h0000_0300, 0, 32'h0000_0204, 0, 0, 1, 1);
        add(1, 0, 0, 32'h0,         1, 32'h0000_0204, 0, 0, 1, 1);
        add(1, 0, 1, 32'h0000_0600, 0, 32'h0000_0204, 0, 0, 1, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0008, 1, 0, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_000C, 0, 0, 0, 1);
        // pending redirect wins over live redirect at release
        add(1, 0, 1, 32'h0000_0400, 0, 32'h0000_000C, 0, 0, 1, 1);
        add(1, 1, 1, 32'h0000_0500, 0, 32'h0000_0400, 1, 0, 0, 1);
        // newer stalled redirect replaces older one
        add(1, 0, 1, 32'h0000_0410, 0, 32'h0000_0400, 0, 0, 1, 1);
        add(1, 0, 1, 32'h0000_0420, 0, 32'h0000_0400, 0, 0, 1, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0420, 1, 0, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0424, 0, 0, 0, 1);
        // misaligned live redirect, then misaligned latched redirect
        add(1, 1, 1, 32'h0000_0202, 0, 32'h0000_0008, 1, 1, 0, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_000C, 0, 0, 0, 1);
        add(1, 0, 1, 32'h0000_0301, 0, 32'h0000_000C, 0, 0, 1, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0008, 1, 1, 0, 1);
        // trap beats redirect when both live in RUN
        add(1, 1, 0, 32'h0,         0, 32'h0000_000C, 0, 0, 0, 1);
        add(1, 1, 1, 32'h0000_0500, 1, 32'h0000_0008, 1, 0, 0, 1);
        // live trap at release beats a pending redirect
        add(1, 0, 1, 32'h0000_0700, 0, 32'h0000_0008, 0, 0, 1, 1);
        add(1, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 0, 0, 1);
        // both valid while stalled latches the trap
        add(1, 1, 0, 32'h0,         0, 32'h0000_000C, 0, 0, 0, 1);
        add(1, 0, 1, 32'h0000_0740, 1, 32'h0000_000C, 0, 0, 1, 1);
        add(1, 1, 0, 32'h0,         0, 32'h0000_0008, 1, 0, 0, 1);

        clrn = 1'b0; we = 1'b0; redir_valid = 1'b0; redir_target = '0; trap_valid = 1'b0;

        n = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], n);
            n++;
        end

        // Sequential wrap past the top of the address space.
        v = '{clrn:1, we:1, rv:1, rt:32'hFFFF_FFFC, tv:0, pc:32'hFFFF_FFFC, flush:1, mis:0, pend:0, valid:1};
        step(v, n++);
        v = '{clrn:1, we:1, rv:0, rt:32'h0, tv:0, pc:32'h0000_0000, flush:0, mis:0, pend:0, valid:1};
        step(v, n++);
        v = '{clrn:1, we:1, rv:0, rt:32'h0, tv:0, pc:32'h0000_0004, flush:0, mis:0, pend:0, valid:1};
        step(v, n++);

        // Reset while a redirect is pending: the entry must vanish.
        v = '{clrn:1, we:0, rv:1, rt:32'h0000_0800, tv:0, pc:32'h0000_0004, flush:0, mis:0, pend:1, valid:1};
        step(v, n++);
        v = '{clrn:0, we:1, rv:0, rt:32'h0, tv:0, pc:32'h0000_0000, flush:0, mis:0, pend:0, valid:0};
        step(v, n++);
        v = '{clrn:1, we:0, rv:0, rt:32'h0, tv:0, pc:32'h0000_0000, flush:0, mis:0, pend:0, valid:1};
        step(v, n++);
        v = '{clrn:1, we:1, rv:0, rt:32'h0, tv:0, pc:32'h0000_0004, flush:0, mis:0, pend:0, valid:1};
        step(v, n++);
        v = '{clrn:1, we:1, rv:0, rt:32'h0, tv:0, pc:32'h0000_0008, flush:0, mis:0, pend:0, valid:1};
        step(v, n++);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_pc_ctrl
